// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: operand width and the immediate-extender mode encodings.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;

   typedef logic [1:0] sext_mode_t;

   localparam sext_mode_t SEXT_SIGN = 2'b00;
   localparam sext_mode_t SEXT_ZERO = 2'b01;
   localparam sext_mode_t SEXT_PASS = 2'b10;
   localparam sext_mode_t SEXT_RSVD = 2'b11;

endpackage

// File: rtl/sext_pipe_if.sv
// Valid/ready request and response bundle between decode, the extender and the operand mux.
interface sext_pipe_if
   import cpu_pkg::*;
#(
   parameter int DATA_W    = CPU_DATA_W,
   parameter int MAX_SHIFT = 3,
   parameter int MSB_W     = $clog2(DATA_W),
   parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
);
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic [MSB_W-1:0]   in_msb;
   logic [SHIFT_W-1:0] in_shift;
   sext_mode_t         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic               out_trunc;
   logic               out_err;

   modport master (
      output in_valid, in_data, in_msb, in_shift, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_trunc, out_err
   );

   modport slave (
      input  in_valid, in_data, in_msb, in_shift, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_trunc, out_err
   );
endinterface

// File: rtl/sext_pipe_core.sv
// Combinational extend step: sign/zero-extend or pass a shifted field from a runtime MSB position.
module sext_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int MSB_W  = $clog2(DATA_W)
) (
   input  logic [DATA_W-1:0] sh,
   input  logic [MSB_W-1:0]  msb,
   input  sext_mode_t        mode,
   output logic [DATA_W-1:0] data
);
   logic [DATA_W-1:0] hi_mask_s;

   // Two-step shift keeps every shift amount below DATA_W; msb==DATA_W-1 yields an empty mask.
   always_comb begin
      hi_mask_s = ({DATA_W{1'b1}} << msb) << 1'b1;
      data      = sh;
      case (mode)
         SEXT_SIGN: begin
            if (sh[msb]) begin
               data = sh | hi_mask_s;
            end else begin
               data = sh & ~hi_mask_s;
            end
         end
         SEXT_ZERO: data = sh & ~hi_mask_s;
         SEXT_PASS: data = sh;
         SEXT_RSVD: data = sh;
         default:   data = sh;
      endcase
   end
endmodule

// File: rtl/sext_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 scales the field, stage 2 extends it.
module sext_pipe
   import cpu_pkg::*;
#(
   parameter int DATA_W    = CPU_DATA_W,
   parameter int MAX_SHIFT = 3,
   parameter int MSB_W     = $clog2(DATA_W),
   parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   sext_pipe_if.slave  bus
);
   logic               s1_valid_r;
   logic               s2_valid_r;
   logic               s1_load_s;
   logic               s2_load_s;
   logic               in_fire_s;
   logic               shift_ovf_s;
   logic [DATA_W-1:0]  top_mask_s;
   logic [DATA_W-1:0]  sh_s;
   logic               trunc_s;
   logic               err_s;
   logic [DATA_W-1:0]  s1_sh_r;
   logic [MSB_W-1:0]   s1_msb_r;
   sext_mode_t         s1_mode_r;
   logic               s1_trunc_r;
   logic               s1_err_r;
   logic [DATA_W-1:0]  ext_s;
   logic [DATA_W-1:0]  out_data_r;
   logic               out_trunc_r;
   logic               out_err_r;

   // An out-of-range shift is only encodable when MAX_SHIFT+1 is not a power of two.
   generate
      if (((1 << SHIFT_W) - 1) > MAX_SHIFT) begin : g_ovf
         assign shift_ovf_s = (32'(bus.in_shift) > 32'(MAX_SHIFT));
      end else begin : g_no_ovf
         assign shift_ovf_s = 1'b0;
      end
   endgenerate

   // in_ready depends combinationally on out_ready so a full pipe still streams at one per cycle.
   assign s2_load_s    = !s2_valid_r || bus.out_ready;
   assign s1_load_s    = !s1_valid_r || s2_load_s;
   assign in_fire_s    = bus.in_valid && s1_load_s;
   assign bus.in_ready = s1_load_s;

   // Stage-1 scaling and detection of set bits lost off the top.
   always_comb begin
      top_mask_s = ~({DATA_W{1'b1}} >> bus.in_shift);
      sh_s       = bus.in_data;
      trunc_s    = 1'b0;
      if (shift_ovf_s) begin
         sh_s    = bus.in_data;
         trunc_s = 1'b0;
      end else begin
         sh_s    = bus.in_data << bus.in_shift;
         trunc_s = |(bus.in_data & top_mask_s);
      end
      err_s = (bus.in_mode == SEXT_RSVD) || shift_ovf_s;
   end

   // Stage-1 register: payload is captured only on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sh_r    <= '0;
         s1_msb_r   <= '0;
         s1_mode_r  <= SEXT_SIGN;
         s1_trunc_r <= 1'b0;
         s1_err_r   <= 1'b0;
      end else begin
         if (s1_load_s) begin
            s1_valid_r <= bus.in_valid;
         end
         if (in_fire_s) begin
            s1_sh_r    <= sh_s;
            s1_msb_r   <= bus.in_msb;
            s1_mode_r  <= bus.in_mode;
            s1_trunc_r <= trunc_s;
            s1_err_r   <= err_s;
         end
      end
   end

   sext_core #(
      .DATA_W (DATA_W),
      .MSB_W  (MSB_W)
   ) u_core (
      .sh   (s1_sh_r),
      .msb  (s1_msb_r),
      .mode (s1_mode_r),
      .data (ext_s)
   );

   // Stage-2 / output register: held unchanged while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         out_data_r  <= '0;
         out_trunc_r <= 1'b0;
         out_err_r   <= 1'b0;
      end else begin
         if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               out_data_r  <= ext_s;
               out_trunc_r <= s1_trunc_r;
               out_err_r   <= s1_err_r;
            end
         end
      end
   end

   assign bus.out_valid = s2_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_trunc = out_trunc_r;
   assign bus.out_err   = out_err_r;
endmodule
